// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: instruction field positions, opcode encodings
// and the fetch-stage state type, so fetch and decode slice fields alike.
package fetch_unit_pkg;

    localparam int XLEN     = 16;
    localparam int OP_LSB   = 0;
    localparam int FUNC_LSB = 3;
    localparam int FIELD_W  = 3;

    localparam logic [FIELD_W-1:0] OP_R = 3'b000;
    localparam logic [FIELD_W-1:0] OP_I = 3'b001;
    localparam logic [FIELD_W-1:0] OP_L = 3'b010;
    localparam logic [FIELD_W-1:0] OP_S = 3'b011;
    localparam logic [FIELD_W-1:0] OP_B = 3'b100;
    localparam logic [FIELD_W-1:0] OP_J = 3'b101;
    localparam logic [FIELD_W-1:0] OP_U = 3'b110;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_slot_buf.sv
// Circular buffer of fetch slots. A slot is reserved (with its PC) when the
// request is granted, filled in order when the word returns, and popped by
// decode once filled. Flush drops every slot at once.
module fetch_slot_buf
    import fetch_unit_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         reserve_i,
    input  logic [W-1:0] reserve_pc_i,
    input  logic         fill_i,
    input  logic [W-1:0] fill_word_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         head_filled_o,
    output logic [W-1:0] head_pc_o,
    output logic [W-1:0] head_word_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]     pc_q   [DEPTH];
    logic [W-1:0]     word_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    fill_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Slot storage and pointers; flush wins over reserve, fill and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
        end else begin
            // Reserve and pop never hit the same slot: that needs an empty or full buffer.
            if (reserve_i) begin
                pc_q[tail_q]     <= reserve_pc_i;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= ptr_inc(tail_q);
            end
            if (fill_i) begin
                word_q[fill_q]   <= fill_word_i;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= ptr_inc(fill_q);
            end
            if (pop_i) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= ptr_inc(head_q);
            end
            case ({reserve_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head view is zeroed until the head slot holds its word.
    always_comb begin
        full_o        = (count_q == CW'(DEPTH));
        head_filled_o = filled_q[head_q];
        head_pc_o     = head_filled_o ? pc_q[head_q] : '0;
        head_word_o   = head_filled_o ? word_q[head_q] : '0;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC-ordered requests, buffers returned
// words with their PCs, and hands them to decode. A redirect flushes the
// buffer and the responses still in flight are counted off and dropped.
//
// Handshakes: a transfer happens on a cycle where valid and ready (imem_req/
// imem_gnt, instr_valid/instr_ready) are both high at the rising clock edge;
// valid never depends on ready within the same cycle.
module fetch_unit #(
    parameter int               XLEN     = fetch_unit_pkg::XLEN,
    parameter int               DEPTH    = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = 2,
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  imem_req,
    output logic [XLEN-1:0]                       imem_addr,
    input  logic                                  imem_gnt,
    input  logic                                  imem_rvalid,
    input  logic [XLEN-1:0]                       imem_rdata,
    input  logic                                  redirect_valid,
    input  logic [XLEN-1:0]                       redirect_target,
    output logic                                  instr_valid,
    input  logic                                  instr_ready,
    output logic [XLEN-1:0]                       instr,
    output logic [XLEN-1:0]                       instr_pc,
    output logic [fetch_unit_pkg::FIELD_W-1:0]    op,
    output logic [fetch_unit_pkg::FIELD_W-1:0]    func,
    output fetch_unit_pkg::fetch_state_e          dbg_state,
    output logic [CNT_W-1:0]                      dbg_drop_cnt
);

    fetch_unit_pkg::fetch_state_e state_q;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [CNT_W-1:0] out_q;
    logic [CNT_W-1:0] drop_q;

    logic             buf_full;
    logic             head_filled;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_word;

    logic             issue;
    logic             pop;
    logic             resp_drop;
    logic             resp_fill;
    logic             resp_dec;
    logic [CNT_W-1:0] out_d;
    logic [CNT_W-1:0] drop_d;

    // Request gating and the counter values after this cycle's response.
    always_comb begin
        imem_req  = (state_q == fetch_unit_pkg::RUN) && !redirect_valid && !buf_full;
        issue     = imem_req && imem_gnt;
        pop       = head_filled && instr_ready;
        resp_drop = imem_rvalid && (drop_q != '0);
        resp_fill = imem_rvalid && (drop_q == '0) && (out_q != '0);
        resp_dec  = imem_rvalid && (out_q != '0);
        out_d     = resp_dec ? out_q - CNT_W'(1) : out_q;
        drop_d    = resp_drop ? drop_q - CNT_W'(1) : drop_q;
    end

    // Fetch FSM with PC and in-flight/drop counters; redirect has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= fetch_unit_pkg::BOOT;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_q <= redirect_target;
            out_q      <= out_d;
            drop_q     <= out_d;
            state_q    <= (out_d != '0) ? fetch_unit_pkg::DRAIN : fetch_unit_pkg::RUN;
        end else begin
            out_q  <= issue ? out_d + CNT_W'(1) : out_d;
            drop_q <= drop_d;
            if (issue) begin
                fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
            end
            case (state_q)
                fetch_unit_pkg::BOOT:  state_q <= fetch_unit_pkg::RUN;
                fetch_unit_pkg::RUN:   state_q <= fetch_unit_pkg::RUN;
                fetch_unit_pkg::DRAIN: if (drop_d == '0) state_q <= fetch_unit_pkg::RUN;
                default:               state_q <= fetch_unit_pkg::BOOT;
            endcase
        end
    end

    fetch_slot_buf #(
        .W     (XLEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (redirect_valid),
        .reserve_i     (issue),
        .reserve_pc_i  (fetch_pc_q),
        .fill_i        (resp_fill),
        .fill_word_i   (imem_rdata),
        .pop_i         (pop),
        .full_o        (buf_full),
        .head_filled_o (head_filled),
        .head_pc_o     (head_pc),
        .head_word_o   (head_word)
    );

    // Head presentation with op/func sliced at the shared field positions.
    always_comb begin
        imem_addr    = fetch_pc_q;
        instr_valid  = head_filled;
        instr        = head_word;
        instr_pc     = head_pc;
        op           = head_word[fetch_unit_pkg::OP_LSB +: fetch_unit_pkg::FIELD_W];
        func         = head_word[fetch_unit_pkg::FUNC_LSB +: fetch_unit_pkg::FIELD_W];
        dbg_state    = state_q;
        dbg_drop_cnt = drop_q;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the 16-bit core. Drives PC-addressed requests to instruction memory and buffers the returned words with their PCs.
- Presents each word, with its op and func fields already sliced, to the decode controller over a valid/ready handshake.
- Consumes the decoder's control-flow outcome (branch taken or jump) as a redirect. On redirect it flushes the buffer and discards responses that are still in flight.

Parameters:
- XLEN, 16, instruction and PC width.
- DEPTH, 2, number of buffer slots; also the maximum number of outstanding memory requests.
- RESET_PC, 16'h0000, PC fetched first after reset.
- PC_STEP, 2, PC increment per accepted request (byte addressing).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address (equals fetch_pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  XLEN  response instruction word.
- redirect_valid  in  1  taken branch or jump from execute.
- redirect_target  in  XLEN  new PC.
- instr_valid  out  1  buffer head holds a filled instruction.
- instr_ready  in  1  decode stage accepts the head.
- instr  out  XLEN  head instruction word.
- instr_pc  out  XLEN  PC of the head instruction.
- op  out  3  instr[2:0].
- func  out  3  instr[5:3].

Behaviour:
- Reset values (asynchronous): state=BOOT; fetch_pc=RESET_PC; buffer empty; outstanding=0; drop_cnt=0; imem_req=0; instr_valid=0.
- Output values while buffer empty or unfilled: instr, instr_pc, op and func are all 0.
- States:
  - BOOT: no request; move to RUN on the next clock.
  - RUN: normal fetch.
  - DRAIN: no requests; stale responses are discarded; move to RUN in the cycle drop_cnt reaches 0.
- Issue:
  - imem_req = (state==RUN) && !redirect_valid && (used slots < DEPTH).
  - Slot reservation: on imem_req && imem_gnt, reserve the tail slot with pc=fetch_pc and state unfilled; set fetch_pc += PC_STEP (mod 2^XLEN, wraps silently); outstanding += 1.
  - imem_req with no grant: hold the same address, no state change.
- Response handling, when imem_rvalid:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Else if outstanding>0: fill the oldest unfilled slot with imem_rdata.
  - Else: ignore the response (protocol error).
  - outstanding decrements on every rvalid while outstanding>0.
- Output and pop:
  - instr_valid = head slot filled.
  - Pop on instr_valid && instr_ready.
  - Best-case fetch-to-decode latency is 1 cycle after rvalid (a registered fill).
- Redirect (priority over everything):
  - Clear all slots; fetch_pc <= redirect_target.
  - drop_cnt <= outstanding - (imem_rvalid ? 1 : 0). A response arriving in the same cycle is discarded.
  - Next state is DRAIN if that value is >0, else RUN.
  - A head handshake in the same cycle is still counted as accepted by the consumer.
- Redirect while in DRAIN: retarget fetch_pc; drop_cnt is recomputed the same way; stay in DRAIN if it is nonzero.
- Redirect while in BOOT: retarget fetch_pc; continue to RUN.
- Simultaneous fill and pop on the same slot is not possible; the head must already be filled to pop.
- Full buffer with outstanding responses: slots are reserved at issue, so responses never overflow.
- Reset mid-operation: all state clears immediately. Responses arriving after reset see outstanding=0 and are ignored.

Decomposition:
- Shared core package:
  - XLEN.
  - OP_LSB=0, FUNC_LSB=3, field width 3.
  - Opcode constants R, I, L, S, B, J, U = 3'b000..3'b110, so fetch and decode share field positions.
  - Fetch state enum {BOOT, RUN, DRAIN}.
- Sub-module fetch_slot_buf holds the DEPTH-entry circular buffer:
  - per slot: {pc, word, filled}.
  - head/tail/fill pointers, plus reserve, fill, pop and flush ports.
- fetch_unit keeps the FSM, the PC and the outstanding/drop counters.

Test Plan:
- Reset and boot:
  - Stimulus: release rst_n; gnt=1, rvalid one cycle after grant, rdata=addr, ready=1.
  - Response: no request in the first cycle; requests at 0x0000, 0x0002, ...; instr_pc=0x0000, instr=0x0000 first, then sequential.
- Backpressure:
  - Stimulus: ready=0, gnt=1.
  - Response: exactly 2 grants (0x0000, 0x0002), then imem_req=0. Raising ready for 1 cycle pops 0x0000, and the next request is 0x0004.
- Redirect with 2 outstanding:
  - Stimulus: response latency 3; redirect to 0x0040 with 2 in flight.
  - Response: state DRAIN; both stale words dropped; no request until drop_cnt=0; then first instr_pc=0x0040.
- Redirect coinciding with rvalid:
  - Stimulus: outstanding=2, rvalid and redirect to 0x0100 in the same cycle.
  - Response: that word is dropped, drop_cnt=1, the next word is dropped, and the first delivered instr_pc is 0x0100.
- Field slicing:
  - Stimulus: rdata 16'h0021.
  - Response: op=3'b001, func=3'b100 (SLTI). rdata 16'h003D gives op=3'b101, func=3'b111.
- Reset mid-DRAIN:
  - Stimulus: assert rst_n low asynchronously while drop_cnt=1, then deliver a late rvalid after release.
  - Response: the outputs clear immediately without waiting for a clock; the late response is ignored; the first delivered instr_pc is RESET_PC.
